// File: rtl/sam_vram_pkg.sv
// Shared types and sizes for the VRAM slot arbiter.
// Used by both build variants (with or without VRAM_DMA_EN).
package sam_vram_pkg;
  localparam int SLOTS   = 8;
  localparam int VRAM_AW = 19;

  typedef enum logic [2:0] {OWN_NONE, OWN_VID_A, OWN_VID_B, OWN_CPU, OWN_DMA} owner_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_CAPTURE} acc_state_t;

  typedef struct packed {
    logic               we;
    logic [1:0]         be;
    logic [VRAM_AW-1:0] addr;
    logic [15:0]        wdata;
  } mem_cmd_t;
endpackage

// File: rtl/vram_slot_arbiter_if.sv
// Bus bundle between the slot arbiter and its clients (video, CPU, optional DMA, SDRAM glue).
// DMA signals exist only when VRAM_DMA_EN is defined.
interface vram_slot_arbiter_if;
  import sam_vram_pkg::*;

  logic               slot_ce, slot_sync;
  logic [2:0]         slot;
  logic               vid_fetch;
  logic [VRAM_AW-1:0] vid_addr1, vid_addr2;
  logic [15:0]        vid_data1, vid_data2;
  logic               vid_valid;
  logic               cpu_req, cpu_we, cpu_ack, cpu_wait;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [15:0]        cpu_wdata, cpu_rdata;
  logic [1:0]         cpu_be;
`ifdef VRAM_DMA_EN
  logic               dma_req, dma_we, dma_ack;
  logic [VRAM_AW-1:0] dma_addr;
  logic [15:0]        dma_wdata, dma_rdata;
`endif
  logic               mem_req, mem_we;
  logic [1:0]         mem_be;
  logic [VRAM_AW-1:0] mem_addr;
  logic [15:0]        mem_wdata, mem_rdata;

  modport slave (
    input  slot_ce, slot_sync, vid_fetch, vid_addr1, vid_addr2,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
`ifdef VRAM_DMA_EN
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_ack,
`endif
    output slot, vid_data1, vid_data2, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output slot_ce, slot_sync, vid_fetch, vid_addr1, vid_addr2,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_rdata,
`ifdef VRAM_DMA_EN
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_ack,
`endif
    input  slot, vid_data1, vid_data2, vid_valid, cpu_rdata, cpu_ack, cpu_wait,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vram_slot_seq.sv
// Slot counter locked to the pixel phase plus the slot -> owner table.
// Owner is reported for the slot being entered, so the access can issue one clock later.
module vram_slot_seq
  import sam_vram_pkg::*;
#(
  parameter int CPU_SLOT = 5
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       slot_ce,
  input  logic       slot_sync,
  input  logic       vid_fetch,
  output logic [2:0] slot,
  output owner_t     next_owner
);
  localparam logic [2:0] CS = 3'(CPU_SLOT);

  logic [2:0] slot_nxt;

  // sync wins over increment; wrap 7->0 falls out of the 3-bit add
  assign slot_nxt = slot_sync ? 3'd0 : slot + 3'd1;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)     slot <= 3'd0;
    else if (slot_ce) slot <= slot_nxt;
  end

  always_comb begin
    next_owner = OWN_DMA;
    if (vid_fetch) begin
      if (slot_nxt == 3'd0)      next_owner = OWN_VID_A;
      else if (slot_nxt == 3'd1) next_owner = OWN_VID_B;
      else if (slot_nxt == CS)   next_owner = OWN_CPU;
    end else if (slot_nxt[1:0] == CS[1:0]) begin
      next_owner = OWN_CPU;
    end
  end
endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter for the shared VRAM port: one access per slot, fixed MEM_LAT read latency.
// Define VRAM_DMA_EN to serve the DMA port in non-CPU/non-video slots; otherwise those slots idle.
module vram_slot_arbiter
  import sam_vram_pkg::*;
#(
  parameter int MEM_LAT  = 2,
  parameter int CPU_SLOT = 5
) (
  input logic                 clk_sys,
  input logic                 reset_n,
  vram_slot_arbiter_if.slave  bus
);
  localparam int WAIT_N = (MEM_LAT > 1) ? MEM_LAT - 1 : 1;

  owner_t     next_owner, own;
  acc_state_t state;
  logic [3:0] cnt;
  logic [2:0] slot_q;
  logic       cpu_busy, cpu_go, dma_go, grant;
  mem_cmd_t   cmd;

  vram_slot_seq #(.CPU_SLOT(CPU_SLOT)) u_seq (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .slot_ce    (bus.slot_ce),
    .slot_sync  (bus.slot_sync),
    .vid_fetch  (bus.vid_fetch),
    .slot       (slot_q),
    .next_owner (next_owner)
  );
  assign bus.slot = slot_q;

  // busy spans ISSUE-end .. ack, so a held request is not re-granted before its ack is seen
  assign cpu_go       = bus.cpu_req & ~cpu_busy;
  assign bus.cpu_wait = bus.cpu_req & ~cpu_busy;
`ifdef VRAM_DMA_EN
  logic dma_busy;
  assign dma_go = bus.dma_req & ~dma_busy;
`else
  assign dma_go = 1'b0;
`endif

  always_comb begin
    grant     = 1'b0;
    cmd.we    = 1'b0;
    cmd.be    = 2'b11;
    cmd.addr  = '0;
    cmd.wdata = '0;
    case (next_owner)
      OWN_VID_A: begin grant = 1'b1; cmd.addr = bus.vid_addr1; end
      OWN_VID_B: begin grant = 1'b1; cmd.addr = bus.vid_addr2; end
      OWN_CPU: begin
        grant = cpu_go;      cmd.we    = bus.cpu_we;    cmd.be = bus.cpu_be;
        cmd.addr = bus.cpu_addr; cmd.wdata = bus.cpu_wdata;
      end
`ifdef VRAM_DMA_EN
      OWN_DMA: begin
        grant = dma_go;      cmd.we    = bus.dma_we;
        cmd.addr = bus.dma_addr; cmd.wdata = bus.dma_wdata;
      end
`endif
      default: grant = dma_go & 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      own           <= OWN_NONE;
      cnt           <= '0;
      cpu_busy      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 2'b00;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.vid_data1 <= '0;
      bus.vid_data2 <= '0;
      bus.vid_valid <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.cpu_ack   <= 1'b0;
`ifdef VRAM_DMA_EN
      dma_busy      <= 1'b0;
      bus.dma_rdata <= '0;
      bus.dma_ack   <= 1'b0;
`endif
    end else begin
      bus.mem_req   <= 1'b0;
      bus.vid_valid <= 1'b0;
      bus.cpu_ack   <= 1'b0;
      if (bus.cpu_ack) cpu_busy <= 1'b0;
`ifdef VRAM_DMA_EN
      bus.dma_ack   <= 1'b0;
      if (bus.dma_ack) dma_busy <= 1'b0;
`endif
      case (state)
        ST_ISSUE: begin
          if (own == OWN_CPU) cpu_busy <= 1'b1;
`ifdef VRAM_DMA_EN
          if (own == OWN_DMA) dma_busy <= 1'b1;
`endif
          cnt   <= 4'(WAIT_N - 1);
          state <= (MEM_LAT > 1) ? ST_WAIT : ST_CAPTURE;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_CAPTURE;
          else             cnt   <= cnt - 4'd1;
        end
        ST_CAPTURE: begin
          case (own)
            OWN_VID_A: bus.vid_data1 <= bus.mem_rdata;
            OWN_VID_B: begin bus.vid_data2 <= bus.mem_rdata; bus.vid_valid <= 1'b1; end
            OWN_CPU: begin
              bus.cpu_ack <= 1'b1;
              if (!bus.mem_we) bus.cpu_rdata <= bus.mem_rdata;
            end
`ifdef VRAM_DMA_EN
            OWN_DMA: begin
              bus.dma_ack <= 1'b1;
              if (!bus.mem_we) bus.dma_rdata <= bus.mem_rdata;
            end
`endif
            default: ;
          endcase
          state <= ST_IDLE;
          own   <= OWN_NONE;
        end
        default: ;
      endcase
      // a slot decision may overlap the previous slot's capture cycle
      if (bus.slot_ce && (state == ST_IDLE || state == ST_CAPTURE) && grant) begin
        state         <= ST_ISSUE;
        own           <= next_owner;
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= cmd.we;
        bus.mem_be    <= cmd.be;
        bus.mem_addr  <= cmd.addr;
        bus.mem_wdata <= cmd.wdata;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_sys)
    if (reset_n && bus.slot_ce)
      assert (state == ST_IDLE || state == ST_CAPTURE)
        else $error("slot_ce arrived before capture: MEM_LAT too long for slot period");
`endif
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Randomized self-checking bench for vram_slot_arbiter against a slot-rule model; DMA checks under VRAM_DMA_EN.
module tb_vram_slot_arbiter;
  import sam_vram_pkg::*;
  localparam int CPU_SLOT = 5;
  localparam int MEM_LAT  = 2;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  vram_slot_arbiter_if bus();
  vram_slot_arbiter #(.MEM_LAT(MEM_LAT), .CPU_SLOT(CPU_SLOT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0, n_bad = 0;
  int n_req, n_cack, n_dack, n_vv, r_cyc, mslot;
  logic [VRAM_AW-1:0] r_addr;
  logic       r_we;
  logic [1:0] r_be;
  logic [15:0] r_wdata, cack_data, dack_data;
  logic [7:0] wait_hist;
  bit cpu_drop, dma_drop;

  // memory contents: a few preset words, everything else an address hash
  logic [15:0] mem_img [logic [VRAM_AW-1:0]];
  function automatic logic [15:0] mem_val(input logic [VRAM_AW-1:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return a[15:0] ^ 16'hC3A5 ^ {13'd0, a[18:16]};
  endfunction

  // slot ownership straight from the rules: 1 VID_A, 2 VID_B, 3 CPU, 4 DMA
  function automatic int exp_owner(input int s, input bit fetch);
    if (fetch) return (s == 0) ? 1 : (s == 1) ? 2 : (s == CPU_SLOT) ? 3 : 4;
    return ((s % 4) == (CPU_SLOT % 4)) ? 3 : 4;
  endfunction

  // memory responder: read data valid only in the cycle MEM_LAT after mem_req
  logic [15:0] rd_pipe;
  always @(posedge clk_sys) begin
    rd_pipe       <= (bus.mem_req && !bus.mem_we) ? mem_val(bus.mem_addr) : 16'h0;
    bus.mem_rdata <= rd_pipe;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one slot: slot_ce cycle then 5 more clocks, observing at negedges
  task automatic tick(input bit sync);
    n_req = 0; n_cack = 0; n_dack = 0; n_vv = 0; wait_hist = '0;
    bus.slot_ce = 1'b1; bus.slot_sync = sync;
    mslot = sync ? 0 : (mslot + 1) % 8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      wait_hist[c] = bus.cpu_wait;
      if (bus.mem_req) begin
        n_req++; r_addr = bus.mem_addr; r_we = bus.mem_we; r_be = bus.mem_be;
        r_wdata = bus.mem_wdata; r_cyc = c;
      end
      if (bus.cpu_ack) begin n_cack++; cack_data = bus.cpu_rdata; end
`ifdef VRAM_DMA_EN
      if (bus.dma_ack) begin n_dack++; dack_data = bus.dma_rdata; end
`endif
      if (bus.vid_valid) n_vv++;
      @(posedge clk_sys); #1;
      bus.slot_ce = 1'b0; bus.slot_sync = 1'b0;
      if (n_cack > 0 && cpu_drop) bus.cpu_req = 1'b0;
`ifdef VRAM_DMA_EN
      if (n_dack > 0 && dma_drop) bus.dma_req = 1'b0;
`endif
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    n_cmp++;
    if ({bus.slot, bus.mem_req, bus.cpu_ack, bus.vid_valid, bus.cpu_wait} !== 7'h0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0", {bus.slot, bus.mem_req, bus.cpu_ack, bus.vid_valid, bus.cpu_wait});
    end
    n_cmp++;
    if ({bus.vid_data1, bus.vid_data2, bus.cpu_rdata} !== 48'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0", {bus.vid_data1, bus.vid_data2, bus.cpu_rdata});
    end
    @(posedge clk_sys); #1 reset_n = 1'b1;
    mslot = 0;
  endtask

  task automatic test_reset_mid_issue;
    int acks = 0;
    bus.vid_fetch = 1'b0;
    tick(1'b1);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h00042; bus.slot_ce = 1'b1;
    @(posedge clk_sys); #1 bus.slot_ce = 1'b0;
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin n_bad++; $display("FAIL issue_before_reset: got %b want 1", bus.mem_req); end
    reset_n = 1'b0; #1;
    n_cmp++;
    if ({bus.mem_req, bus.slot} !== 4'h0) begin
      n_bad++; $display("FAIL async_abort: got req=%b slot=%0d want 0/0", bus.mem_req, bus.slot);
    end
    repeat (4) begin @(negedge clk_sys); if (bus.cpu_ack) acks++; end
    bus.cpu_req = 1'b0;
    @(posedge clk_sys); #1 reset_n = 1'b1;
    repeat (6) begin @(negedge clk_sys); if (bus.cpu_ack) acks++; end
    n_cmp++;
    if (acks != 0 || bus.slot !== 3'd0) begin
      n_bad++; $display("FAIL abort_no_ack: got acks=%0d slot=%0d want 0/0", acks, bus.slot);
    end
    @(posedge clk_sys); #1;
    mslot = 0;
  endtask

  task automatic test_vid_fetch;
    mem_img[19'h00100] = 16'hA5A5; mem_img[19'h00180] = 16'h5A5A;
    bus.vid_fetch = 1'b1; bus.vid_addr1 = 19'h00100; bus.vid_addr2 = 19'h00180;
    tick(1'b1);
    n_cmp++;
    if (n_req != 1 || r_addr !== 19'h00100 || r_we !== 1'b0 || r_cyc != 1) begin
      n_bad++; $display("FAIL vid_a_issue: got n=%0d addr=%h we=%b cyc=%0d want 1/00100/0/1", n_req, r_addr, r_we, r_cyc);
    end
    tick(1'b0);
    n_cmp++;
    if (n_req != 1 || r_addr !== 19'h00180) begin
      n_bad++; $display("FAIL vid_b_issue: got n=%0d addr=%h want 1/00180", n_req, r_addr);
    end
    n_cmp++;
    if (bus.vid_data1 !== 16'hA5A5 || bus.vid_data2 !== 16'h5A5A || n_vv != 1) begin
      n_bad++; $display("FAIL vid_data: got %h/%h valid=%0d want a5a5/5a5a/1", bus.vid_data1, bus.vid_data2, n_vv);
    end
  endtask

  task automatic test_cpu_wait;
    tick(1'b0);                                   // slot 2
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h12345;
    for (int k = 0; k < 2; k++) begin             // slots 3,4: DMA slots, CPU kept waiting
      tick(1'b0);
      n_cmp++;
      if (n_req != 0 || wait_hist[5:0] !== 6'h3F) begin
        n_bad++; $display("FAIL cpu_wait_slot%0d: got n=%0d wait=%b want 0/111111", mslot, n_req, wait_hist[5:0]);
      end
    end
    tick(1'b0);                                   // slot 5
    n_cmp++;
    if (n_req != 1 || r_addr !== 19'h12345 || wait_hist[2:0] !== 3'b011) begin
      n_bad++; $display("FAIL cpu_slot5_issue: got n=%0d addr=%h wait=%b want 1/12345/011", n_req, r_addr, wait_hist[2:0]);
    end
    n_cmp++;
    if (n_cack != 1 || cack_data !== mem_val(19'h12345)) begin
      n_bad++; $display("FAIL cpu_read_ack: got acks=%0d data=%h want 1/%h", n_cack, cack_data, mem_val(19'h12345));
    end
    @(negedge clk_sys);
    n_cmp++;
    if (bus.cpu_wait !== 1'b0) begin n_bad++; $display("FAIL cpu_wait_after: got %b want 0", bus.cpu_wait); end
    @(posedge clk_sys); #1;
  endtask

  task automatic test_idle_map;
    bus.vid_fetch = 1'b0;
    tick(1'b1); tick(1'b0); tick(1'b0);           // now slot 2
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h0F00D;
    for (int k = 0; k < 3; k++) begin             // slots 3,4,5
      tick(1'b0);
      n_cmp++;
      if (n_req != ((k == 2) ? 1 : 0) || (k == 2 && r_addr !== 19'h0F00D)) begin
        n_bad++; $display("FAIL idle_map_a slot%0d: got n=%0d addr=%h", mslot, n_req, r_addr);
      end
    end
    tick(1'b0);                                   // slot 6
    bus.cpu_req = 1'b1; bus.cpu_addr = 19'h4BEAD;
    for (int k = 0; k < 3; k++) begin             // slots 7,0,1
      tick(1'b0);
      n_cmp++;
      if (n_req != ((k == 2) ? 1 : 0) || (k == 2 && (r_addr !== 19'h4BEAD || cack_data !== mem_val(19'h4BEAD)))) begin
        n_bad++; $display("FAIL idle_map_b slot%0d: got n=%0d addr=%h data=%h", mslot, n_req, r_addr, cack_data);
      end
    end
  endtask

  task automatic test_contention;
    int cpu_hits = 0;
    int o;
    logic [VRAM_AW-1:0] ea;
    int en;
    bus.vid_fetch = 1'b1; bus.vid_addr1 = 19'h01111; bus.vid_addr2 = 19'h02222;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 19'h0AAAA; cpu_drop = 1'b0;
`ifdef VRAM_DMA_EN
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 19'h05555; dma_drop = 1'b0;
`endif
    for (int k = 0; k < 8; k++) begin
      tick(k == 0);
      o  = exp_owner(mslot, 1'b1);
      ea = (o == 1) ? 19'h01111 : (o == 2) ? 19'h02222 : (o == 3) ? 19'h0AAAA : 19'h05555;
`ifdef VRAM_DMA_EN
      en = 1;
`else
      en = (o == 4) ? 0 : 1;
`endif
      if (n_req == 1 && r_addr === 19'h0AAAA) cpu_hits++;
      n_cmp++;
      if (n_req != en || (en == 1 && r_addr !== ea)) begin
        n_bad++; $display("FAIL contention slot%0d: got n=%0d addr=%h want %0d/%h", mslot, n_req, r_addr, en, ea);
      end
    end
    n_cmp++;
    if (cpu_hits != 1) begin n_bad++; $display("FAIL cpu_only_slot5: got %0d grants want 1", cpu_hits); end
    bus.cpu_req = 1'b0; cpu_drop = 1'b1;
`ifdef VRAM_DMA_EN
    bus.dma_req = 1'b0; dma_drop = 1'b1;
`endif
  endtask

  task automatic test_sync_write;
    logic [15:0] prev;
    bus.vid_fetch = 1'b0;
    tick(1'b1); tick(1'b0); tick(1'b0); tick(1'b0);   // slot 3
    tick(1'b1);
    n_cmp++;
    if (bus.slot !== 3'd0) begin n_bad++; $display("FAIL sync_slot: got %0d want 0", bus.slot); end
    prev = bus.cpu_rdata;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 19'h3C3C3;
    bus.cpu_wdata = 16'hBEEF; bus.cpu_be = 2'b01;
    tick(1'b0);                                   // slot 1 is a CPU slot
    n_cmp++;
    if (n_req != 1 || r_we !== 1'b1 || r_be !== 2'b01 || r_wdata !== 16'hBEEF || r_addr !== 19'h3C3C3) begin
      n_bad++; $display("FAIL cpu_write_cmd: got n=%0d we=%b be=%b wd=%h addr=%h", n_req, r_we, r_be, r_wdata, r_addr);
    end
    n_cmp++;
    if (n_cack != 1 || bus.cpu_rdata !== prev) begin
      n_bad++; $display("FAIL cpu_write_ack: got acks=%0d rdata=%h want 1/%h", n_cack, bus.cpu_rdata, prev);
    end
    bus.cpu_we = 1'b0; bus.cpu_be = 2'b11;
  endtask

  task automatic test_random;
    bit pend = 1'b0;
    int o;
    bit served;
    logic [15:0] prev;
    logic [VRAM_AW-1:0] ea;
    for (int i = 0; i < 64; i++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1; bus.cpu_req = 1'b1;
        bus.cpu_we = 1'($urandom_range(0, 1)); bus.cpu_addr = 19'($urandom);
        bus.cpu_wdata = 16'($urandom); bus.cpu_be = 2'($urandom_range(1, 3));
      end
      if ($urandom_range(0, 3) == 0) bus.vid_fetch = ~bus.vid_fetch;
      bus.vid_addr1 = 19'($urandom); bus.vid_addr2 = 19'($urandom);
      prev = bus.cpu_rdata;
      tick(i == 0);
      o      = exp_owner(mslot, bus.vid_fetch);
      served = (o == 3) && pend;
      ea     = (o == 1) ? bus.vid_addr1 : (o == 2) ? bus.vid_addr2 : bus.cpu_addr;
      n_cmp++;
      if (bus.slot !== 3'(mslot) || n_req != ((o <= 2 || served) ? 1 : 0) ||
          (n_req == 1 && (r_addr !== ea || r_we !== (served ? bus.cpu_we : 1'b0)))) begin
        n_bad++; $display("FAIL rnd_issue %0d: slot=%0d own=%0d n=%0d addr=%h we=%b want addr=%h", i, bus.slot, o, n_req, r_addr, r_we, ea);
      end
      n_cmp++;
      if (n_cack != (served ? 1 : 0) ||
          (served && !bus.cpu_we && cack_data !== mem_val(bus.cpu_addr)) ||
          (served && bus.cpu_we && bus.cpu_rdata !== prev) ||
          (pend && !served && wait_hist[5:0] !== 6'h3F)) begin
        n_bad++; $display("FAIL rnd_cpu %0d: own=%0d acks=%0d data=%h wait=%b", i, o, n_cack, bus.cpu_rdata, wait_hist[5:0]);
      end
      n_cmp++;
      if (n_vv != ((o == 2) ? 1 : 0) || (o == 1 && bus.vid_data1 !== mem_val(bus.vid_addr1)) ||
          (o == 2 && bus.vid_data2 !== mem_val(bus.vid_addr2))) begin
        n_bad++; $display("FAIL rnd_vid %0d: own=%0d valid=%0d d1=%h d2=%h", i, o, n_vv, bus.vid_data1, bus.vid_data2);
      end
      if (served) pend = 1'b0;
    end
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    bus.slot_ce = 1'b0; bus.slot_sync = 1'b0; bus.vid_fetch = 1'b0;
    bus.vid_addr1 = '0; bus.vid_addr2 = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = 2'b11;
`ifdef VRAM_DMA_EN
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
`endif
    cpu_drop = 1'b1; dma_drop = 1'b1; mslot = 0;
    test_reset;
    test_reset_mid_issue;
    test_vid_fetch;
    test_cpu_wait;
    test_idle_map;
    test_contention;
    test_sync_write;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
